// File: rtl/sram.sv
// rtl/sram.sv - dual-bank SRAM: input bank (2 read ports) and output bank (1 read port)
module sram #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_wen,
   input  logic [ADDR_WIDTH-1:0] in_wadr,
   input  logic [DATA_WIDTH-1:0] in_wdata,
   input  logic                  out_wen,
   input  logic [ADDR_WIDTH-1:0] out_wadr,
   input  logic [DATA_WIDTH-1:0] out_wdata,
   input  logic                  op1_ren,
   input  logic [ADDR_WIDTH-1:0] op1_radr,
   output logic [DATA_WIDTH-1:0] op1_rdata,
   input  logic                  op2_ren,
   input  logic [ADDR_WIDTH-1:0] op2_radr,
   output logic [DATA_WIDTH-1:0] op2_rdata,
   input  logic                  out_ren,
   input  logic [ADDR_WIDTH-1:0] out_radr,
   output logic [DATA_WIDTH-1:0] out_rdata
);

   // Index width covers exactly DEPTH words; out-of-range addresses are filtered
   // before indexing so high address bits can never alias onto a valid word.
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return {1'b0, a} < DEPTH_LIM;
   endfunction

   function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] a);
      return a[IDX_W-1:0];
   endfunction

   // Storage is deliberately not reset; contents survive rst_n.
   logic [DATA_WIDTH-1:0] in_mem_q  [DEPTH];
   logic [DATA_WIDTH-1:0] out_mem_q [DEPTH];

   logic                  in_we;
   logic                  out_we;
   logic [DATA_WIDTH-1:0] op1_rdata_d, op1_rdata_q;
   logic [DATA_WIDTH-1:0] op2_rdata_d, op2_rdata_q;
   logic [DATA_WIDTH-1:0] out_rdata_d, out_rdata_q;

   // Write strobes: blocked during reset and for addresses beyond the bank.
   always_comb begin
      in_we  = in_wen  && rst_n && in_range(in_wadr);
      out_we = out_wen && rst_n && in_range(out_wadr);
   end

   // Input-bank array write.
   always_ff @(posedge clk) begin
      if (in_we) begin
         in_mem_q[to_idx(in_wadr)] <= in_wdata;
      end
   end

   // Output-bank array write.
   always_ff @(posedge clk) begin
      if (out_we) begin
         out_mem_q[to_idx(out_wadr)] <= out_wdata;
      end
   end

   // Next read data: sample the pre-edge array (read-first), hold when not enabled.
   always_comb begin
      op1_rdata_d = op1_rdata_q;
      op2_rdata_d = op2_rdata_q;
      out_rdata_d = out_rdata_q;
      if (op1_ren) begin
         op1_rdata_d = in_range(op1_radr) ? in_mem_q[to_idx(op1_radr)] : '0;
      end
      if (op2_ren) begin
         op2_rdata_d = in_range(op2_radr) ? in_mem_q[to_idx(op2_radr)] : '0;
      end
      if (out_ren) begin
         out_rdata_d = in_range(out_radr) ? out_mem_q[to_idx(out_radr)] : '0;
      end
   end

   // Read data registers, cleared immediately when reset asserts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op1_rdata_q <= '0;
         op2_rdata_q <= '0;
         out_rdata_q <= '0;
      end else begin
         op1_rdata_q <= op1_rdata_d;
         op2_rdata_q <= op2_rdata_d;
         out_rdata_q <= out_rdata_d;
      end
   end

   assign op1_rdata = op1_rdata_q;
   assign op2_rdata = op2_rdata_q;
   assign out_rdata = out_rdata_q;

endmodule

// File: tb/tb_sram.sv
// tb/tb_sram.sv - directed self-checking bench for sram
module tb_sram;

   localparam int DW = 128;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_wen, out_wen, op1_ren, op2_ren, out_ren;
   logic [AW-1:0] in_wadr, out_wadr, op1_radr, op2_radr, out_radr;
   logic [DW-1:0] in_wdata, out_wdata;
   logic [DW-1:0] op1_rdata, op2_rdata, out_rdata;

   // Small instance (DEPTH < 2^ADDR_WIDTH) for out-of-range address behaviour.
   logic          s_in_wen, s_out_wen, s_op1_ren, s_op2_ren, s_out_ren;
   logic [4:0]    s_in_wadr, s_out_wadr, s_op1_radr, s_op2_radr, s_out_radr;
   logic [7:0]    s_in_wdata, s_out_wdata;
   logic [7:0]    s_op1_rdata, s_op2_rdata, s_out_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sram dut (
      .clk(clk), .rst_n(rst_n),
      .in_wen(in_wen), .in_wadr(in_wadr), .in_wdata(in_wdata),
      .out_wen(out_wen), .out_wadr(out_wadr), .out_wdata(out_wdata),
      .op1_ren(op1_ren), .op1_radr(op1_radr), .op1_rdata(op1_rdata),
      .op2_ren(op2_ren), .op2_radr(op2_radr), .op2_rdata(op2_rdata),
      .out_ren(out_ren), .out_radr(out_radr), .out_rdata(out_rdata)
   );

   sram #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(16)) dut_s (
      .clk(clk), .rst_n(rst_n),
      .in_wen(s_in_wen), .in_wadr(s_in_wadr), .in_wdata(s_in_wdata),
      .out_wen(s_out_wen), .out_wadr(s_out_wadr), .out_wdata(s_out_wdata),
      .op1_ren(s_op1_ren), .op1_radr(s_op1_radr), .op1_rdata(s_op1_rdata),
      .op2_ren(s_op2_ren), .op2_radr(s_op2_radr), .op2_rdata(s_op2_rdata),
      .out_ren(s_out_ren), .out_radr(s_out_radr), .out_rdata(s_out_rdata)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then return on the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      in_wen = 0; out_wen = 0; op1_ren = 0; op2_ren = 0; out_ren = 0;
      s_in_wen = 0; s_out_wen = 0; s_op1_ren = 0; s_op2_ren = 0; s_out_ren = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      in_wadr = '0; out_wadr = '0; op1_radr = '0; op2_radr = '0; out_radr = '0;
      in_wdata = '0; out_wdata = '0;
      s_in_wadr = '0; s_out_wadr = '0; s_op1_radr = '0; s_op2_radr = '0; s_out_radr = '0;
      s_in_wdata = '0; s_out_wdata = '0;

      #2;
      check("reset_op1", op1_rdata, 0);
      check("reset_op2", op2_rdata, 0);
      check("reset_out", out_rdata, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Dual-bank write on the same edge, then read back.
      in_wen = 1; in_wadr = 0; in_wdata = 137;
      out_wen = 1; out_wadr = 100; out_wdata = 42;
      step();
      idle();
      op1_ren = 1; op1_radr = 0; out_ren = 1; out_radr = 100;
      step();
      check("dual_op1", op1_rdata, 137);
      check("dual_out", out_rdata, 42);

      // Overwrite both banks, read input bank through op2.
      idle();
      in_wen = 1; in_wadr = 0; in_wdata = 27;
      out_wen = 1; out_wadr = 100; out_wdata = 100;
      step();
      idle();
      op2_ren = 1; op2_radr = 0; out_ren = 1; out_radr = 100;
      step();
      check("ovw_op2", op2_rdata, 27);
      check("ovw_out", out_rdata, 100);

      // Same address in both banks is distinct storage.
      idle();
      in_wen = 1; in_wadr = 5; in_wdata = 7;
      out_wen = 1; out_wadr = 5; out_wdata = 9;
      step();
      idle();
      op1_ren = 1; op1_radr = 5; out_ren = 1; out_radr = 5;
      step();
      check("iso_op1", op1_rdata, 7);
      check("iso_out", out_rdata, 9);

      // Both input-bank ports on the same address.
      idle();
      op1_ren = 1; op1_radr = 5; op2_ren = 1; op2_radr = 5;
      step();
      check("same_adr_op1", op1_rdata, 7);
      check("same_adr_op2", op2_rdata, 7);

      // Read-first collision, then new value, then hold.
      idle();
      in_wen = 1; in_wadr = 0; in_wdata = 55;
      op1_ren = 1; op1_radr = 0;
      step();
      check("rdfirst_old", op1_rdata, 27);
      in_wen = 0;
      step();
      check("rdfirst_new", op1_rdata, 55);
      op1_ren = 0; op1_radr = 5;
      step();
      check("hold_op1", op1_rdata, 55);

      // Dual port at the lowest and highest address.
      idle();
      in_wen = 1; in_wadr = 0; in_wdata = 1;
      step();
      in_wadr = 1023; in_wdata = 2;
      step();
      idle();
      op1_ren = 1; op1_radr = 0; op2_ren = 1; op2_radr = 1023; out_ren = 1; out_radr = 100;
      step();
      check("dp_op1", op1_rdata, 1);
      check("dp_op2", op2_rdata, 2);
      check("dp_out", out_rdata, 100);

      // Asynchronous reset mid-cycle while reads are enabled; writes blocked.
      in_wen = 1; in_wadr = 0; in_wdata = 99;
      out_wen = 1; out_wadr = 100; out_wdata = 77;
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_op1", op1_rdata, 0);
      check("areset_op2", op2_rdata, 0);
      check("areset_out", out_rdata, 0);
      step();
      check("rst_hold_op1", op1_rdata, 0);
      rst_n = 1'b1;
      idle();
      op1_ren = 1; op1_radr = 0; out_ren = 1; out_radr = 100;
      step();
      check("rst_nowr_in", op1_rdata, 1);
      check("rst_nowr_out", out_rdata, 100);

      // Small instance: last valid address, out-of-range write and read.
      idle();
      s_in_wen = 1; s_in_wadr = 5; s_in_wdata = 8'hAA;
      step();
      s_in_wadr = 15; s_in_wdata = 8'h5C;
      step();
      s_in_wadr = 21; s_in_wdata = 8'hBB;
      step();
      idle();
      s_op1_ren = 1; s_op1_radr = 5; s_op2_ren = 1; s_op2_radr = 15;
      step();
      check("oor_wr_ignored", {120'd0, s_op1_rdata}, 128'hAA);
      check("last_adr", {120'd0, s_op2_rdata}, 128'h5C);
      s_op1_radr = 21; s_op2_radr = 16;
      step();
      check("oor_rd_zero_21", {120'd0, s_op1_rdata}, 0);
      check("oor_rd_zero_16", {120'd0, s_op2_rdata}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sram.md
SRAM -- requirements
Module: sram

Interface
REQ-001 Parameter DATA_WIDTH, default 128, word width in bits; SHALL size all data ports.
REQ-002 Parameter ADDR_WIDTH, default 10, address width; SHALL size all address ports.
REQ-003 Parameter DEPTH, default 1024, words per bank; SHALL satisfy DEPTH <= 2^ADDR_WIDTH.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_wen  input  1  input-bank write enable.
REQ-007 in_wadr  input  ADDR_WIDTH  input-bank write address.
REQ-008 in_wdata  input  DATA_WIDTH  input-bank write data.
REQ-009 out_wen  input  1  output-bank write enable.
REQ-010 out_wadr  input  ADDR_WIDTH  output-bank write address.
REQ-011 out_wdata  input  DATA_WIDTH  output-bank write data.
REQ-012 op1_ren / op2_ren  input  1  read enables, input-bank read ports 1 and 2.
REQ-013 op1_radr / op2_radr  input  ADDR_WIDTH  read addresses, input-bank ports 1 and 2.
REQ-014 op1_rdata / op2_rdata  output  DATA_WIDTH  registered read data, input-bank ports 1 and 2.
REQ-015 out_ren  input  1  output-bank read enable.
REQ-016 out_radr  input  ADDR_WIDTH  output-bank read address.
REQ-017 out_rdata  output  DATA_WIDTH  registered output-bank read data.

Function
REQ-018 The block SHALL contain two independent banks of DEPTH x DATA_WIDTH: input bank (in_* write, op1/op2 read) and output bank (out_* write, out read).
REQ-019 Same address values in different banks SHALL be distinct storage; in and out writes in the same cycle SHALL never conflict.
REQ-020 Write: rising edge with wen=1 and address < DEPTH SHALL store wdata at that address; wen=0 SHALL leave the bank unchanged.
REQ-021 Read: rising edge with ren=1 SHALL load rdata with the addressed word; valid one cycle after the enabling edge (latency 1).
REQ-022 With ren=0, the corresponding rdata SHALL hold its last value.
REQ-023 op1 and op2 SHALL read independently in the same cycle, including from the same address.
REQ-024 Read and write of the same address on the same edge SHALL be read-first: rdata returns the pre-write word; new data is visible from the next read.
REQ-025 Write address >= DEPTH SHALL be ignored; read address >= DEPTH SHALL load rdata with zero.
REQ-026 Memory contents SHALL be undefined before first write; no initialization is required.

Reset
REQ-027 rst_n=0 SHALL immediately (asynchronously) clear op1_rdata, op2_rdata and out_rdata to 0.
REQ-028 Memory array contents SHALL NOT be cleared by reset; writes with wen=1 SHALL be blocked while rst_n=0.
REQ-029 Reset deassertion SHALL be followed by normal operation on the next rising edge; reads/writes in flight during reset assertion SHALL be discarded.

Verification
REQ-030 Reset: assert rst_n=0 mid-read -> all three rdata outputs 0 without a clock edge.
REQ-031 Dual-bank write: in_wadr=0 in_wdata=137 and out_wadr=100 out_wdata=42 same edge; then op1_radr=0, out_radr=100 read -> op1_rdata=137, out_rdata=42 one cycle later.
REQ-032 Overwrite: in_wadr=0 <- 27, out_wadr=100 <- 100; then op2_radr=0, out_radr=100 read -> op2_rdata=27, out_rdata=100.
REQ-033 Bank isolation: in_wadr=5 <- 7, out_wadr=5 <- 9 same edge -> op1 read 5 = 7, out read 5 = 9.
REQ-034 Read-first/hold: write 0 <- 55 while op1 reads 0 (old 27) -> op1_rdata=27; next read -> 55; with op1_ren=0, op1_rdata stays 55.
REQ-035 Dual port: op1_radr=0 and op2_radr=1023 same edge after writes 0 <- 1, 1023 <- 2 -> op1_rdata=1, op2_rdata=2.
